// File: rtl/free_index_manager_pkg.sv
// rtl/free_index_manager_pkg.sv - shared packet-buffer sizing constants and index type
//
// Purpose: single place where the packet buffer depth and the matching index
// type live, so the free-index manager and its clients agree on widths.
// Ports: none (package).

package free_index_manager_pkg;

  // Depth of the packet buffer served by the free-index manager.
  localparam int PKT_BUF_ENTRIES = 8;

  // Width of a buffer index at the default depth.
  localparam int PKT_IDX_W = $clog2(PKT_BUF_ENTRIES);

  typedef logic [PKT_IDX_W-1:0] pkt_idx_t;

endpackage

// File: rtl/next_free_index_comb.sv
// rtl/next_free_index_comb.sv - combinational priority encoder, highest set bit wins
//
// Purpose: picks the highest-numbered set bit of a bitmap.
// Ports:
//   bitmap  in   N   candidate bits (1 = free)
//   found   out  1   at least one bit of bitmap is set
//   index   out  W   position of the highest set bit; 0 when nothing is set

module next_free_index_comb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] bitmap,
  output logic         found,
  output logic [W-1:0] index
);

  // Ascending scan: later (higher) hits overwrite earlier ones.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (bitmap[i]) begin
        found = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/free_index_manager.sv
// rtl/free_index_manager.sv - free-slot bitmap owner with allocate/release clients
//
// Purpose: keeps the free-slot bitmap of the packet buffer, offers the highest
// free index to the allocator through a valid/ready handshake, accepts index
// returns from the releaser and flags double-free / out-of-range releases.
// Ports:
//   clk              in   1              clock
//   rst              in   1              synchronous active-high reset
//   flush            in   1              pulse: every slot becomes free
//   alloc_valid      out  1              a free index is offered
//   alloc_index      out  IDX_W          offered index (held when !alloc_valid)
//   alloc_ready      in   1              allocator takes alloc_index this cycle
//   release_valid    in   1              return release_index to the pool
//   release_index    in   IDX_W          index being returned
//   free_count       out  IDX_W+1        number of free slots
//   free_bitmap      out  NUM_ENTRIES    bit i = 1 means slot i is free
//   err_double_free  out  1              pulse: released slot was already free
//   err_range        out  1              pulse: release_index >= NUM_ENTRIES

module free_index_manager
  import free_index_manager_pkg::*;
#(
  parameter int  NUM_ENTRIES = PKT_BUF_ENTRIES,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  output logic                   alloc_valid,
  output logic [IDX_W-1:0]       alloc_index,
  input  logic                   alloc_ready,
  input  logic                   release_valid,
  input  logic [IDX_W-1:0]       release_index,
  output logic [IDX_W:0]         free_count,
  output logic [NUM_ENTRIES-1:0] free_bitmap,
  output logic                   err_double_free,
  output logic                   err_range
);

  localparam logic [IDX_W:0]   ENTRIES_C  = (IDX_W + 1)'(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] TOP_IDX_C  = IDX_W'(NUM_ENTRIES - 1);

  function automatic logic [IDX_W:0] popcount(input logic [NUM_ENTRIES-1:0] bits);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      n = n + {{IDX_W{1'b0}}, bits[i]};
    end
    return n;
  endfunction

  logic                   take;
  logic                   release_oob;
  logic                   release_was_free;
  logic [NUM_ENTRIES-1:0] take_mask;
  logic [NUM_ENTRIES-1:0] release_mask;
  logic [NUM_ENTRIES-1:0] next_bitmap;
  logic                   next_dbl;
  logic                   next_rng;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_index;

  assign take        = alloc_valid && alloc_ready;
  // Widen by one bit so the comparison is meaningful for non-power-of-two depths.
  assign release_oob = {1'b0, release_index} >= ENTRIES_C;

  // One-hot decodes built by comparison so an out-of-range index simply
  // decodes to nothing instead of selecting a bit that does not exist.
  always_comb begin
    take_mask    = '0;
    release_mask = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      take_mask[i]    = take && (alloc_index == IDX_W'(i));
      release_mask[i] = release_index == IDX_W'(i);
    end
  end

  assign release_was_free = |(free_bitmap & release_mask);

  always_comb begin
    next_bitmap = free_bitmap;
    next_dbl    = 1'b0;
    next_rng    = 1'b0;
    if (flush) begin
      next_bitmap = '1;
    end else begin
      next_bitmap = next_bitmap & ~take_mask;
      if (release_valid) begin
        if (release_oob) begin
          next_rng = 1'b1;
        end else if (release_was_free || (take && (release_index == alloc_index))) begin
          // A slot being handed out right now is still free in the current
          // bitmap, so returning it is a double-free; the allocation stands.
          next_dbl = 1'b1;
        end else begin
          next_bitmap = next_bitmap | release_mask;
        end
      end
    end
  end

  // Offer is chosen from next_bitmap so a slot taken this cycle is never
  // re-offered, and a slot released this cycle is offered next cycle.
  next_free_index_comb #(
    .N (NUM_ENTRIES),
    .W (IDX_W)
  ) u_next_free (
    .bitmap (next_bitmap),
    .found  (sel_found),
    .index  (sel_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      free_bitmap     <= '1;
      free_count      <= ENTRIES_C;
      alloc_valid     <= 1'b1;
      alloc_index     <= TOP_IDX_C;
      err_double_free <= 1'b0;
      err_range       <= 1'b0;
    end else begin
      free_bitmap     <= next_bitmap;
      free_count      <= popcount(next_bitmap);
      alloc_valid     <= sel_found;
      // Hold the last offer while empty; consumers ignore it without valid.
      if (sel_found) begin
        alloc_index <= sel_index;
      end
      err_double_free <= next_dbl;
      err_range       <= next_rng;
    end
  end

endmodule

// File: doc/free_index_manager.md
Name: free_index_manager

Overview:
- Owns the free-slot bitmap of the packet buffer and serves two clients: the allocator, which pops the next free index through a valid/ready handshake, and the releaser, which returns indices when packets retire.
- Sits in the packet controller between the packet ingress path (allocation) and the transmit/retire path (release).
- Reuses the existing combinational priority encoder to select the next free index.
- Flags double-free and out-of-range releases.

Parameters:
- NUM_ENTRIES, 8, number of buffer slots; minimum 2; need not be a power of two.
- IDX_W, $clog2(NUM_ENTRIES), width of an index (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  single-cycle pulse; marks every slot free.
- alloc_valid  output  1  a free index is offered on alloc_index.
- alloc_index  output  IDX_W  offered free index.
- alloc_ready  input  1  consumer takes alloc_index this cycle.
- release_valid  input  1  return release_index to the free pool; always accepted.
- release_index  input  IDX_W  index being returned.
- free_count  output  IDX_W+1  number of free slots.
- free_bitmap  output  NUM_ENTRIES  bit i = 1 means slot i is free.
- err_double_free  output  1  one-cycle pulse: released index was already free.
- err_range  output  1  one-cycle pulse: release_index >= NUM_ENTRIES.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - bitmap all ones (bits >= NUM_ENTRIES do not exist).
  - free_count = NUM_ENTRIES.
  - alloc_valid = 1.
  - alloc_index = NUM_ENTRIES-1.
  - err_double_free = 0, err_range = 0.
- All outputs are registered.
- next_bitmap is computed combinationally from the current bitmap:
  - If flush: all ones. Alloc and release in that cycle are discarded and no error is raised.
  - Otherwise, start from the current bitmap.
  - Alloc handshake (alloc_valid && alloc_ready): clear bit alloc_index.
  - Release (release_valid): if release_index >= NUM_ENTRIES, no change and err_range = 1 next cycle.
  - Release where the bit is already set in the current bitmap: no change and err_double_free = 1 next cycle.
  - Otherwise the release sets the bit.
  - Release of the index being allocated in the same cycle counts as a double-free: the allocation wins, the bit ends cleared, and err_double_free pulses.
- Selection: highest-numbered free bit wins (priority encoder on next_bitmap). alloc_valid and alloc_index are registered from next_bitmap.
- Latency:
  - A handshake in cycle N never re-offers the same index in cycle N+1.
  - A release in cycle N is visible on alloc_* and free_bitmap in cycle N+1.
- alloc_valid = 0 when next_bitmap is all zero. alloc_index is then held at its previous value; consumers must ignore it.
- alloc_index must stay stable while alloc_valid && !alloc_ready, unless a release of a higher index or a flush occurs. In those cases the offer may change; the consumer samples only on the handshake.
- free_count: registered popcount of next_bitmap, range 0..NUM_ENTRIES. It never wraps.
- Error pulses last exactly one cycle per offending release. Both are 0 in the cycle after reset or flush.
- Reset mid-operation: state returns to the reset values on the next edge; in-flight handshakes are lost.

Decomposition:
- Shared package:
  - an index typedef sized from the buffer depth;
  - the PKT_BUF_ENTRIES constant (default 8).
- Sub-module: instantiate next_free_index_comb on next_bitmap for index selection.
- Popcount is a local function; no further sub-modules.

Test Plan:
- Reset then idle -> alloc_valid=1, alloc_index=7, free_count=8, free_bitmap=8'hFF.
- alloc_ready held high for 8 cycles -> indices 7,6,5,4,3,2,1,0 on successive cycles; then alloc_valid=0, free_count=0, free_bitmap=8'h00.
- From empty, release 3 then release 5 on consecutive cycles -> alloc_index=3 one cycle after the first release, then 5; free_count 1 then 2.
- With slot 2 free, release 2 -> err_double_free pulses for 1 cycle, free_count unchanged. In the same cycle as a handshake on index 6, release 6 -> bit 6 ends 0 and err_double_free=1.
- NUM_ENTRIES=6: release_index=7 -> err_range=1 for 1 cycle, bitmap unchanged.
- From bitmap 8'h00, flush with simultaneous release of 1 -> bitmap 8'hFF, alloc_index=7, no error pulses. Asserting rst while allocating gives the same result.
